// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped I/O window holding the HEX/LEDR/LEDG output
// registers, debounced KEY/SW inputs with sticky status, and a tick timer.

// Synchronise and debounce a vector of asynchronous inputs.
// upd pulses on the edge where the debounced value changes.
module mmio_debounce #(
    parameter int W            = 4,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         upd
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [W-1:0]  sync1, sync2, prev, deb;
    logic [CW-1:0] cnt, cnt_next;

    // Stability count: restart on any change or when already settled; update
    // the debounced value on the edge that would bring the count to its limit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        cnt_next = '0;
        upd      = 1'b0;
        if ((sync2 == prev) && (sync2 != deb))
            cnt_next = cnt + 1'b1;
        if ((sync2 != deb) && (cnt_next == CW'(DEBOUNCE_CYC - 1)))
            upd = 1'b1;
    end

    // Two-flop synchroniser, change detector and debounced value.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            if (upd) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

    assign dout = deb;
endmodule

module mmio_periph #(
    parameter int              DBITS        = 32,
    parameter logic [DBITS-1:0] BASE        = 32'hF0000000,
    parameter int              NHEX         = 4,
    parameter logic [4*NHEX-1:0] HEXRESET   = 16'hDEAD,
    parameter int              NLEDR        = 10,
    parameter int              NLEDG        = 8,
    parameter int              NKEY         = 4,
    parameter int              NSW          = 10,
    parameter int              DEBOUNCE_CYC = 500000,
    parameter int              TICKCYC      = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DBITS-1:0]  addr,
    input  logic [DBITS-1:0]  wdata,
    input  logic              we,
    input  logic              re,
    output logic [DBITS-1:0]  rdata,
    output logic              hit,
    input  logic [NKEY-1:0]   key_n,
    input  logic [NSW-1:0]    sw,
    output logic [4*NHEX-1:0] hex,
    output logic [NLEDR-1:0]  ledr,
    output logic [NLEDG-1:0]  ledg
);
    localparam int PW = (TICKCYC > 1) ? $clog2(TICKCYC) : 1;

    localparam logic [11:0] OFF_HEX   = 12'h000;
    localparam logic [11:0] OFF_LEDR  = 12'h004;
    localparam logic [11:0] OFF_LEDG  = 12'h008;
    localparam logic [11:0] OFF_KDATA = 12'h010;
    localparam logic [11:0] OFF_SDATA = 12'h014;
    localparam logic [11:0] OFF_KCTRL = 12'h018;
    localparam logic [11:0] OFF_SCTRL = 12'h01C;
    localparam logic [11:0] OFF_TCNT  = 12'h020;
    localparam logic [11:0] OFF_TLIM  = 12'h024;
    localparam logic [11:0] OFF_TCTRL = 12'h028;

    logic [11:0]      off;
    logic             wr, rd;
    logic [NKEY-1:0]  kdata;
    logic [NSW-1:0]   sdata;
    logic             k_upd, s_upd;
    logic [1:0]       kst, sst, tst;  // {overrun, ready}
    logic [DBITS-1:0] tcnt, tlim;
    logic [PW-1:0]    presc;
    logic             tick, tcnt_wr, t_set;

    assign hit = (addr[DBITS-1:12] == BASE[DBITS-1:12]);
    assign off = addr[11:0];
    assign wr  = we & hit;
    assign rd  = re & hit;

    mmio_debounce #(.W(NKEY), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_db (
        .clk(clk), .reset(reset), .din(~key_n), .dout(kdata), .upd(k_upd)
    );

    mmio_debounce #(.W(NSW), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_db (
        .clk(clk), .reset(reset), .din(sw), .dout(sdata), .upd(s_upd)
    );

    // Sticky {overrun, ready}: a set beats any clear in the same cycle.
    function automatic logic [1:0] status_next(input logic [1:0] cur, input logic set,
                                               input logic clr_rdy, input logic clr_ovr);
        if (set)
            return {cur[1] | cur[0], 1'b1};
        return {cur[1] & ~clr_ovr, cur[0] & ~clr_rdy};
    endfunction

    assign tick    = (presc == PW'(TICKCYC - 1));
    assign tcnt_wr = wr && (off == OFF_TCNT);
    assign t_set   = tick && !tcnt_wr && (tlim != '0) && (tcnt == tlim - 1'b1);

    // Output registers written from the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex  <= HEXRESET;
            ledr <= '0;
            ledg <= '0;
        end else if (wr) begin
            if (off == OFF_HEX)  hex  <= wdata[4*NHEX-1:0];
            if (off == OFF_LEDR) ledr <= wdata[NLEDR-1:0];
            if (off == OFF_LEDG) ledg <= wdata[NLEDG-1:0];
        end
    end

    // Status bits for the key, switch and timer groups.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kst <= '0;
            sst <= '0;
            tst <= '0;
        end else begin
            kst <= status_next(kst, k_upd,
                               (rd && off == OFF_KDATA) || (wr && off == OFF_KCTRL && !wdata[0]),
                               wr && off == OFF_KCTRL && !wdata[1]);
            sst <= status_next(sst, s_upd,
                               (rd && off == OFF_SDATA) || (wr && off == OFF_SCTRL && !wdata[0]),
                               wr && off == OFF_SCTRL && !wdata[1]);
            tst <= status_next(tst, t_set,
                               wr && off == OFF_TCTRL && !wdata[0],
                               wr && off == OFF_TCTRL && !wdata[1]);
        end
    end

    // Prescaler, count and limit; a count write overrides a same-cycle tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tcnt  <= '0;
            tlim  <= '0;
        end else begin
            if (wr && off == OFF_TLIM)
                tlim <= wdata;
            if (tcnt_wr) begin
                tcnt  <= wdata;
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
                tcnt  <= t_set ? '0 : tcnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Combinational read mux; silent outside the window so it can be OR-ed.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_HEX:   rdata = DBITS'(hex);
                OFF_LEDR:  rdata = DBITS'(ledr);
                OFF_LEDG:  rdata = DBITS'(ledg);
                OFF_KDATA: rdata = DBITS'(kdata);
                OFF_SDATA: rdata = DBITS'(sdata);
                OFF_KCTRL: rdata = DBITS'(kst);
                OFF_SCTRL: rdata = DBITS'(sst);
                OFF_TCNT:  rdata = tcnt;
                OFF_TLIM:  rdata = tlim;
                OFF_TCTRL: rdata = DBITS'(tst);
                default:   rdata = DBITS'(32'hDEADBEEF);
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: directed bench for mmio_periph with short debounce/tick.
module tb_mmio_periph;
    localparam logic [31:0] B       = 32'hF0000000;
    localparam logic [31:0] A_HEX   = B + 32'h00;
    localparam logic [31:0] A_LEDR  = B + 32'h04;
    localparam logic [31:0] A_LEDG  = B + 32'h08;
    localparam logic [31:0] A_KDATA = B + 32'h10;
    localparam logic [31:0] A_SDATA = B + 32'h14;
    localparam logic [31:0] A_KCTRL = B + 32'h18;
    localparam logic [31:0] A_SCTRL = B + 32'h1C;
    localparam logic [31:0] A_TCNT  = B + 32'h20;
    localparam logic [31:0] A_TLIM  = B + 32'h24;
    localparam logic [31:0] A_TCTRL = B + 32'h28;
    localparam logic [31:0] A_BAD   = B + 32'h30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        we = 1'b0, re = 1'b0, hit;
    logic [3:0]  key_n = 4'hF;
    logic [9:0]  sw = '0;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [31:0] d;

    int n_checks = 0;
    int n_errors = 0;

    mmio_periph #(.DEBOUNCE_CYC(4), .TICKCYC(3)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .hit(hit), .key_n(key_n), .sw(sw),
        .hex(hex), .ledr(ledr), .ledg(ledg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write; the store takes effect on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        addr = a; wdata = v; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    // One load cycle; optional read strobe, data sampled before the edge.
    task automatic bus_read(input logic [31:0] a, input logic do_re, output logic [31:0] v);
        addr = a; re = do_re;
        #1 v = rdata;
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    // Look at a register without a bus cycle or side effect.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1 check(tag, rdata, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #23 reset = 1'b0;
        edges(1);

        // Reset state
        peek("rst_hex_rd", A_HEX, 32'h0000DEAD);
        peek("rst_ledr_rd", A_LEDR, 32'h0);
        peek("rst_ledg_rd", A_LEDG, 32'h0);
        peek("rst_kctrl", A_KCTRL, 32'h0);
        check("rst_hex_pin", 32'(hex), 32'hDEAD);
        check("hit_in", 32'(hit), 32'd1);
        addr = 32'h0000_1000;
        #1 check("hit_out", 32'(hit), 32'd0);
        check("rdata_out", rdata, 32'h0);

        // Output registers
        bus_write(A_HEX, 32'h12345678);
        bus_write(A_LEDR, 32'h3FF);
        bus_write(A_LEDG, 32'hAB);
        check("hex_pin", 32'(hex), 32'h5678);
        check("ledr_pin", 32'(ledr), 32'h3FF);
        check("ledg_pin", 32'(ledg), 32'hAB);
        peek("hex_rd", A_HEX, 32'h5678);
        peek("ledr_rd", A_LEDR, 32'h3FF);
        peek("ledg_rd", A_LEDG, 32'hAB);
        bus_write(A_BAD, 32'hFFFFFFFF);
        check("bad_hex", 32'(hex), 32'h5678);
        check("bad_ledr", 32'(ledr), 32'h3FF);
        check("bad_ledg", 32'(ledg), 32'hAB);
        peek("bad_rd", A_BAD, 32'hDEADBEEF);

        // Key debounce: clean step lands exactly 6 edges later
        key_n = 4'hE;
        edges(5);
        peek("kdata_e5", A_KDATA, 32'h0);
        edges(1);
        peek("kdata_e6", A_KDATA, 32'h1);
        peek("kctrl_rdy", A_KCTRL, 32'h1);

        // 3-cycle glitch is rejected
        key_n = 4'hC;
        edges(3);
        key_n = 4'hE;
        edges(10);
        peek("glitch_kdata", A_KDATA, 32'h1);
        peek("glitch_kctrl", A_KCTRL, 32'h1);

        // Second update before a read sets overrun
        key_n = 4'hC;
        edges(6);
        peek("kdata_2nd", A_KDATA, 32'h3);
        peek("kctrl_ovr", A_KCTRL, 32'h3);
        bus_read(A_KDATA, 1'b1, d);
        check("kdata_read", d, 32'h3);
        peek("kctrl_rdclr", A_KCTRL, 32'h2);
        bus_write(A_KCTRL, 32'h1);
        peek("kctrl_wrclr", A_KCTRL, 32'h0);

        // Read clear on the update edge loses to the set
        key_n = 4'hE;
        edges(5);
        bus_read(A_KDATA, 1'b1, d);
        check("kdata_pre", d, 32'h3);
        peek("kctrl_setwin", A_KCTRL, 32'h1);
        peek("kdata_post", A_KDATA, 32'h1);

        // Switch group
        sw = 10'h155;
        edges(6);
        peek("sdata", A_SDATA, 32'h155);
        peek("sctrl", A_SCTRL, 32'h1);

        // Timer with limit 5, one tick per 3 cycles
        bus_write(A_TLIM, 32'd5);
        bus_write(A_TCNT, 32'd0);
        peek("tlim_rd", A_TLIM, 32'd5);
        edges(2);
        peek("tcnt_e2", A_TCNT, 32'd0);
        edges(1);
        peek("tcnt_e3", A_TCNT, 32'd1);
        edges(3);
        peek("tcnt_e6", A_TCNT, 32'd2);
        edges(3);
        peek("tcnt_e9", A_TCNT, 32'd3);
        edges(3);
        peek("tcnt_e12", A_TCNT, 32'd4);
        peek("tctrl_e12", A_TCTRL, 32'h0);
        edges(3);
        peek("tcnt_wrap", A_TCNT, 32'd0);
        peek("tctrl_rdy", A_TCTRL, 32'h1);
        edges(15);
        peek("tcnt_wrap2", A_TCNT, 32'd0);
        peek("tctrl_ovr", A_TCTRL, 32'h3);
        bus_write(A_TCTRL, 32'h0);
        peek("tctrl_clr", A_TCTRL, 32'h0);

        // Count write on a tick edge wins and suppresses ready
        bus_write(A_TLIM, 32'd6);
        bus_write(A_TCNT, 32'd5);
        edges(2);
        bus_write(A_TCNT, 32'd7);
        peek("tcnt_wrtick", A_TCNT, 32'd7);
        peek("tctrl_wrtick", A_TCTRL, 32'h0);
        edges(2);
        peek("tcnt_psc2", A_TCNT, 32'd7);
        edges(1);
        peek("tcnt_psc3", A_TCNT, 32'd8);

        // Free-run across the 32-bit wrap
        bus_write(A_TLIM, 32'd0);
        bus_write(A_TCNT, 32'hFFFFFFFE);
        edges(3);
        peek("free_ff", A_TCNT, 32'hFFFFFFFF);
        edges(3);
        peek("free_0", A_TCNT, 32'h0);
        peek("free_tctrl", A_TCTRL, 32'h0);

        // Asynchronous reset mid-debounce and mid-count
        bus_write(A_TLIM, 32'd9);
        key_n = 4'h0;
        edges(3);
        #2 reset = 1'b1;
        #1;
        check("ar_hex", 32'(hex), 32'hDEAD);
        check("ar_ledr", 32'(ledr), 32'h0);
        check("ar_ledg", 32'(ledg), 32'h0);
        peek("ar_kdata", A_KDATA, 32'h0);
        peek("ar_sdata", A_SDATA, 32'h0);
        peek("ar_kctrl", A_KCTRL, 32'h0);
        peek("ar_sctrl", A_SCTRL, 32'h0);
        peek("ar_tcnt", A_TCNT, 32'h0);
        peek("ar_tlim", A_TLIM, 32'h0);
        edges(2);
        reset = 1'b0;
        edges(3);
        peek("ar_kdata_post", A_KDATA, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
